// File: rtl/rdata_packetizer.sv
// rdata_packetizer: groups read-data beats into packets of cfg_pkt_beats,
// closing a partial packet early on an idle timeout or a flush request.
module rdata_packetizer #(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = 64,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic [15:0]            cfg_pkt_beats,
    input  logic [TIMER_WIDTH-1:0] cfg_timeout,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_RDATA_tdata,
    input  logic [KEEP_WIDTH-1:0]  S_AXIS_RDATA_tkeep,
    input  logic                   S_AXIS_RDATA_tlast,
    input  logic                   S_AXIS_RDATA_tvalid,
    output logic                   S_AXIS_RDATA_tready,
    output logic [DATA_WIDTH-1:0]  M_AXIS_PKT_tdata,
    output logic [KEEP_WIDTH-1:0]  M_AXIS_PKT_tkeep,
    output logic                   M_AXIS_PKT_tlast,
    output logic                   M_AXIS_PKT_tvalid,
    input  logic                   M_AXIS_PKT_tready,
    output logic [31:0]            pkt_count,
    output logic [15:0]            timeout_count
);
    logic                   hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [KEEP_WIDTH-1:0]  hold_keep_q, hold_keep_d;
    logic [15:0]            hold_idx_q, hold_idx_d;
    logic [15:0]            pkt_idx_q, pkt_idx_d;
    logic [TIMER_WIDTH-1:0] idle_q, idle_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0]  out_keep_q, out_keep_d;
    logic                   out_last_q, out_last_d;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;
    logic [15:0]            to_cnt_q, to_cnt_d;

    logic [15:0] n_beats, n_last, cap_idx;
    logic        out_free, s_fire, hold_last, timeout_hit;
    logic        release_c, rel_last;
    logic        unused_tlast;

    assign unused_tlast = S_AXIS_RDATA_tlast;

    assign n_beats     = (cfg_pkt_beats == 16'd0) ? 16'd1 : cfg_pkt_beats;
    assign n_last      = n_beats - 16'd1;
    assign out_free    = !out_valid_q || M_AXIS_PKT_tready;
    assign S_AXIS_RDATA_tready = axi_aresetn && (!hold_valid_q || out_free);
    assign s_fire      = S_AXIS_RDATA_tvalid && S_AXIS_RDATA_tready;
    assign hold_last   = (hold_idx_q == n_last);
    assign timeout_hit = (cfg_timeout != '0) && (idle_q >= cfg_timeout);
    assign rel_last    = hold_last || timeout_hit || flush;
    assign release_c   = hold_valid_q && out_free &&
                         (s_fire || hold_last || timeout_hit || flush);

    // A lowered packet length can leave pkt_idx past the end: close there.
    always_comb begin
        cap_idx = pkt_idx_q;
        if (release_c && rel_last)
            cap_idx = 16'd0;
        else if (pkt_idx_q >= n_beats)
            cap_idx = n_last;
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_keep_d  = hold_keep_q;
        hold_idx_d   = hold_idx_q;
        pkt_idx_d    = pkt_idx_q;
        idle_d       = idle_q;
        out_valid_d  = out_valid_q && !M_AXIS_PKT_tready;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        pkt_cnt_d    = pkt_cnt_q;
        to_cnt_d     = to_cnt_q;

        if (release_c) begin
            hold_valid_d = 1'b0;
            out_valid_d  = 1'b1;
            out_data_d   = hold_data_q;
            out_keep_d   = hold_keep_q;
            out_last_d   = rel_last;
            if (rel_last)
                pkt_idx_d = 16'd0;
            if (!hold_last && (timeout_hit || flush))
                to_cnt_d = to_cnt_q + 16'd1;
        end

        if (s_fire) begin
            hold_valid_d = 1'b1;
            hold_data_d  = S_AXIS_RDATA_tdata;
            hold_keep_d  = S_AXIS_RDATA_tkeep;
            hold_idx_d   = cap_idx;
            pkt_idx_d    = (cap_idx == n_last) ? 16'd0 : cap_idx + 16'd1;
        end

        if (s_fire || release_c)
            idle_d = '0;
        else if (hold_valid_q && (idle_q != '1))
            idle_d = idle_q + 1'b1;

        if (out_valid_q && M_AXIS_PKT_tready && out_last_q)
            pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_keep_q  <= '0;
            hold_idx_q   <= '0;
            pkt_idx_q    <= '0;
            idle_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            to_cnt_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_keep_q  <= hold_keep_d;
            hold_idx_q   <= hold_idx_d;
            pkt_idx_q    <= pkt_idx_d;
            idle_q       <= idle_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            pkt_cnt_q    <= pkt_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign M_AXIS_PKT_tdata  = out_data_q;
    assign M_AXIS_PKT_tkeep  = out_keep_q;
    assign M_AXIS_PKT_tlast  = out_last_q;
    assign M_AXIS_PKT_tvalid = out_valid_q;
    assign pkt_count         = pkt_cnt_q;
    assign timeout_count     = to_cnt_q;
endmodule

// File: doc/rdata_packetizer.md
RDATA_PACKETIZER -- requirements
Module: rdata_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, read-data beat width.
REQ-002 SHALL have parameter KEEP_WIDTH, default 64, equal to DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMER_WIDTH, default 16, idle-timer and cfg_timeout width.
REQ-004 SHALL have ports, one per line:
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  reset; synchronous, active-low.
- cfg_pkt_beats  in  16  beats per packet; 0 is treated as 1.
- cfg_timeout  in  TIMER_WIDTH  idle cycles before a partial packet is closed; 0 disables the timeout.
- flush  in  1  level; closes any open partial packet.
- S_AXIS_RDATA_tdata  in  DATA_WIDTH  beat from the read-data FIFO.
- S_AXIS_RDATA_tkeep  in  KEEP_WIDTH  byte enables.
- S_AXIS_RDATA_tlast  in  1  ignored.
- S_AXIS_RDATA_tvalid  in  1  beat valid.
- S_AXIS_RDATA_tready  out  1  beat accepted.
- M_AXIS_PKT_tdata  out  DATA_WIDTH  packetized beat.
- M_AXIS_PKT_tkeep  out  KEEP_WIDTH  byte enables, passed through.
- M_AXIS_PKT_tlast  out  1  end of packet.
- M_AXIS_PKT_tvalid  out  1  output valid.
- M_AXIS_PKT_tready  in  1  downstream ready.
- pkt_count  out  32  count of packets emitted.
- timeout_count  out  16  count of packets closed by timeout or flush.

Function
REQ-005 SHALL contain one hold register (hold_valid, data, keep, hold_idx) and one output register driving M_AXIS_PKT_*.
REQ-006 SHALL define the following terms:
- out_free = !M_AXIS_PKT_tvalid || M_AXIS_PKT_tready.
- s_fire = S_AXIS_RDATA_tvalid && S_AXIS_RDATA_tready.
- N = max(cfg_pkt_beats, 1).
REQ-007 SHALL drive S_AXIS_RDATA_tready = !hold_valid || out_free, combinationally from registered state and M_AXIS_PKT_tready.
REQ-008 SHALL capture every accepted beat into the hold register; the beat is never written directly to the output register.
REQ-009 SHALL set hold_last = (hold_idx == N-1).
REQ-010 SHALL set timeout_hit = (cfg_timeout != 0) && (idle_timer >= cfg_timeout).
REQ-011 SHALL release the hold register into the output register when hold_valid && out_free && (s_fire || hold_last || timeout_hit || flush).
REQ-012 SHALL set the released beat's tlast = hold_last || timeout_hit || flush.
REQ-013 SHALL, when a release coincides with s_fire, put the new beat into the hold register in the same cycle, so back-to-back input sustains one beat per cycle.
REQ-014 SHALL keep a pkt_idx register:
- A captured beat gets hold_idx = 0 if a same-cycle release has tlast=1; otherwise hold_idx = pkt_idx.
- pkt_idx then becomes (hold_idx+1) modulo N.
- A release with tlast=1 and no same-cycle capture sets pkt_idx to 0.
REQ-015 SHALL reset idle_timer to 0 on any capture or release, and otherwise increment it, saturating, while hold_valid.
REQ-016 SHALL hold the output register stable while M_AXIS_PKT_tvalid && !M_AXIS_PKT_tready.
REQ-017 SHALL pass tkeep through unchanged.
REQ-018 SHALL never emit a beat with tkeep zeroed or a beat with no data.
REQ-019 SHALL increment pkt_count on each output handshake with tlast=1, wrapping at 2^32.
REQ-020 SHALL increment timeout_count, wrapping, on each release whose tlast=1 is caused by timeout_hit or flush while hold_last is 0.
REQ-021 SHALL sample cfg_pkt_beats at capture; a change mid-packet affects only beats captured afterwards.
REQ-022 SHALL, when pkt_idx >= N because N was lowered, treat the next capture as the last beat (hold_idx = N-1).
REQ-023 SHALL have latency from input handshake to M_AXIS_PKT_tvalid of 2 cycles for a last beat and for a beat followed by another beat, and cfg_timeout+2 cycles for a timed-out beat.
REQ-024 SHALL, when flush is asserted with hold_valid=0, take no action and emit no empty packet.

Reset
REQ-025 SHALL, on axi_aresetn=0 at a rising edge, clear all of the following:
- hold_valid, M_AXIS_PKT_tvalid, M_AXIS_PKT_tlast.
- pkt_idx, idle_timer.
- pkt_count, timeout_count.
REQ-026 SHALL drive S_AXIS_RDATA_tready=0 while axi_aresetn=0.
REQ-027 SHALL reset tdata/tkeep registers to 0.
REQ-028 SHALL, on reset mid-packet, discard any held beat without emitting it.

Verification
REQ-029 SHALL cover: cfg_pkt_beats=4, 8 back-to-back beats, M_AXIS_PKT_tready=1 -> 8 output beats, one per cycle, tlast on beats 4 and 8, pkt_count=2.
REQ-030 SHALL cover: cfg_pkt_beats=4, cfg_timeout=10, 3 beats then idle -> third beat emitted with tlast=1 exactly 12 cycles after its input handshake, timeout_count=1; next beat starts a new packet at index 0.
REQ-031 SHALL cover: cfg_pkt_beats=0 and cfg_pkt_beats=1 -> every output beat has tlast=1.
REQ-032 SHALL cover: cfg_pkt_beats=4, M_AXIS_PKT_tready toggled randomly 50% over 1000 beats -> no loss, no duplication, data in order, tlast every 4th beat, output stable while stalled.
REQ-033 SHALL cover: cfg_timeout=0, 2 beats, flush pulsed for 1 cycle on cycle 20 -> second beat emitted with tlast=1; flush with hold empty -> no output.
REQ-034 SHALL cover: axi_aresetn pulsed low with 1 beat held -> held beat never appears; all outputs and counters are 0 after reset.
